// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table and blank pattern.
package sseg_pkg;

    localparam logic [6:0] SSEG_OFF = 7'h7F;

    // gfedcba, active-low, indexed by nibble value 0-F
    localparam logic [6:0] GLYPH_ROM [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        return GLYPH_ROM[nib];
    endfunction

endpackage

// File: rtl/sseg_prescaler.sv
// Digit-slot counter: slot_tick on the last cycle of a slot, in_blank during the leading dark cycles.
module sseg_prescaler #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    output logic slot_tick,
    output logic in_blank
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);

    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        slot_tick = (presc_q == PW'(REFRESH_DIV - 1));
        presc_d   = slot_tick ? '0 : presc_q + PW'(1);
        in_blank  = (32'(presc_q) < BLANK_CYCLES);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed N-digit seven-segment driver with per-frame input snapshot.
// Define SSEG_LZ_BLANK_EN to enable leading-zero suppression.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    output logic [6:0]                seven_seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     anodes
);

    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic                    slot_tick, in_blank;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;
    logic [NUM_DIGITS-1:0]   en_snap_q, en_snap_d;
    logic                    pend_q, pend_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic [NUM_DIGITS-1:0]   supp;
    logic [3:0]              nib;
    logic                    visible;

    sseg_prescaler #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_presc (
        .clk       (clk),
        .reset_n   (reset_n),
        .slot_tick (slot_tick),
        .in_blank  (in_blank)
    );

`ifdef SSEG_LZ_BLANK_EN
    // Walk from the most significant digit down; a digit is blanked while every nibble at or above it is zero.
    always_comb begin
        logic        zero_run;
        int unsigned i;
        zero_run = 1'b1;
        i        = 0;
        supp     = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            i        = NUM_DIGITS - 1 - k;
            zero_run = zero_run & (snap_q[4*i +: 4] == 4'h0);
            supp[i]  = zero_run & (i != 0);
        end
    end
`else
    always_comb begin
        supp = '0;
    end
`endif

    always_comb begin
        idx_d     = idx_q;
        snap_d    = snap_q;
        dp_snap_d = dp_snap_q;
        en_snap_d = en_snap_q;
        pend_d    = 1'b0;

        if (slot_tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        // Reload on the first edge after reset and at the last cycle of each frame.
        if (pend_q || (slot_tick && idx_q == IDX_LAST)) begin
            snap_d    = value;
            dp_snap_d = dp_in;
            en_snap_d = digit_en;
        end

        nib      = snap_q[{idx_q, 2'b00} +: 4];
        visible  = en_snap_q[idx_q] && !in_blank && !supp[idx_q];
        anodes_d = '1;
        seg_d    = SSEG_OFF;
        dp_d     = 1'b1;
        if (visible) begin
            anodes_d[idx_q] = 1'b0;
            seg_d           = glyph(nib);
            dp_d            = ~dp_snap_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q     <= '0;
            snap_q    <= '0;
            dp_snap_q <= '0;
            en_snap_q <= '0;
            pend_q    <= 1'b1;
            seg_q     <= SSEG_OFF;
            dp_q      <= 1'b1;
            anodes_q  <= '1;
        end else begin
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            dp_snap_q <= dp_snap_d;
            en_snap_q <= en_snap_d;
            pend_q    <= pend_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            anodes_q  <= anodes_d;
        end
    end

    assign seven_seg = seg_q;
    assign dp        = dp_q;
    assign anodes    = anodes_q;

endmodule
